// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake engine: directions, game status,
// renderer pixel codes and the direction-reversal test.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DIE  = 2'b10,
    OVER = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    PIX_NONE = 2'b00,
    PIX_HEAD = 2'b01,
    PIX_BODY = 2'b10,
    PIX_WALL = 2'b11
  } pix_t;

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    is_reverse = 1'b0;
    case (a)
      UP:    is_reverse = (b == DOWN);
      DOWN:  is_reverse = (b == UP);
      LEFT:  is_reverse = (b == RIGHT);
      RIGHT: is_reverse = (b == LEFT);
    endcase
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Step divider: counts 0..STEP_DIV-1 while enabled and pulses tick on the
// wrap cycle; clear restarts the count from zero.
module snake_step_timer #(
  parameter int STEP_DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = enable && (count == CW'(STEP_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake core: segment buffer, game FSM, collision and per-pixel query.
// Define WRAP_WALLS_EN for a wall-less playfield with wrapping head moves.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int MAX_LEN     = 16,
  parameter int INIT_LEN    = 3,
  parameter int STEP_DIV    = 12500000,
  parameter int CELL_SHIFT  = 4,
  parameter int FLASH_STEPS = 6,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          left_press,
  input  logic          right_press,
  input  logic          up_press,
  input  logic          down_press,
  input  logic          grow,
  input  logic [9:0]    pix_x,
  input  logic [9:0]    pix_y,
  output logic [1:0]    snake,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] len,
  output logic [1:0]    game_status,
  output logic          step,
  output logic          hit_wall,
  output logic          hit_body,
  output logic          die_flash
);

  localparam int FW = $clog2(FLASH_STEPS + 1);

  status_t       state_q, state_d;
  dir_t          dir_q, pending_dir, cur_dir, req_dir;
  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len_q;
  logic [FW-1:0] flash_cnt;
  logic          grow_pend, req_valid, tick, init;
  logic          do_move, wall_evt, body_evt, wall_hit, body_hit, pix_wall;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic [9:0]    cell_x, cell_y;
  pix_t          pix_code;

  snake_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (init),
    .enable (state_q == RUN || state_q == DIE),
    .tick   (tick)
  );

  // Candidate head uses the direction that takes effect at this tick.
  always_comb begin
    next_x = seg_x[0];
    next_y = seg_y[0];
    case (pending_dir)
      UP:    next_y = (seg_y[0] == '0) ? YW'(GRID_H - 1) : seg_y[0] - 1'b1;
      DOWN:  next_y = (seg_y[0] == YW'(GRID_H - 1)) ? '0 : seg_y[0] + 1'b1;
      LEFT:  next_x = (seg_x[0] == '0) ? XW'(GRID_W - 1) : seg_x[0] - 1'b1;
      RIGHT: next_x = (seg_x[0] == XW'(GRID_W - 1)) ? '0 : seg_x[0] + 1'b1;
    endcase
`ifdef WRAP_WALLS_EN
    wall_hit = 1'b0;
`else
    wall_hit = (next_x == '0) || (next_x == XW'(GRID_W - 1)) ||
               (next_y == '0) || (next_y == YW'(GRID_H - 1));
`endif
    body_hit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if (((k + 1 < int'(len_q)) || (grow_pend && k < int'(len_q))) &&
          seg_x[k] == next_x && seg_y[k] == next_y) begin
        body_hit = 1'b1;
      end
    end
  end

  always_comb begin
    cur_dir   = tick ? pending_dir : dir_q;
    req_valid = 1'b0;
    req_dir   = pending_dir;
    if (up_press && !is_reverse(UP, cur_dir)) begin
      req_valid = 1'b1;
      req_dir   = UP;
    end else if (down_press && !is_reverse(DOWN, cur_dir)) begin
      req_valid = 1'b1;
      req_dir   = DOWN;
    end else if (left_press && !is_reverse(LEFT, cur_dir)) begin
      req_valid = 1'b1;
      req_dir   = LEFT;
    end else if (right_press && !is_reverse(RIGHT, cur_dir)) begin
      req_valid = 1'b1;
      req_dir   = RIGHT;
    end
  end

  always_comb begin
    state_d  = state_q;
    init     = 1'b0;
    do_move  = 1'b0;
    wall_evt = 1'b0;
    body_evt = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          init    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          if (wall_hit) begin
            wall_evt = 1'b1;
            state_d  = DIE;
          end else if (body_hit) begin
            body_evt = 1'b1;
            state_d  = DIE;
          end else begin
            do_move = 1'b1;
          end
        end
      end
      DIE: begin
        if (tick && flash_cnt == FW'(FLASH_STEPS - 1)) begin
          state_d = OVER;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step     <= 1'b0;
      hit_wall <= 1'b0;
      hit_body <= 1'b0;
    end else begin
      state_q  <= state_d;
      step     <= do_move;
      hit_wall <= wall_evt;
      hit_body <= body_evt;
    end
  end

  // Start re-runs the reset initialisation so a new game matches power-up.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= XW'(GRID_W / 2 - i);
        seg_y[i] <= YW'(GRID_H / 2);
      end
      len_q       <= LW'(INIT_LEN);
      dir_q       <= RIGHT;
      pending_dir <= RIGHT;
      grow_pend   <= 1'b0;
      flash_cnt   <= '0;
      die_flash   <= 1'b0;
    end else begin
      if (state_q == RUN) begin
        if (tick) dir_q <= pending_dir;
        if (req_valid) pending_dir <= req_dir;
      end
      grow_pend <= do_move ? grow : (grow_pend | grow);
      if (do_move) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= next_x;
        seg_y[0] <= next_y;
        if (grow_pend && len_q < LW'(MAX_LEN)) len_q <= len_q + 1'b1;
      end
      if (wall_evt || body_evt) begin
        flash_cnt <= '0;
        die_flash <= 1'b0;
      end else if (state_q == DIE && tick) begin
        flash_cnt <= flash_cnt + 1'b1;
        die_flash <= (flash_cnt == FW'(FLASH_STEPS - 1)) ? 1'b0 : ~die_flash;
      end
    end
  end

  // Renderer query: later assignments take priority (head over body over wall).
  always_comb begin
    cell_x   = pix_x >> CELL_SHIFT;
    cell_y   = pix_y >> CELL_SHIFT;
`ifdef WRAP_WALLS_EN
    pix_wall = 1'b0;
`else
    pix_wall = (cell_x == '0) || (cell_x == 10'(GRID_W - 1)) ||
               (cell_y == '0) || (cell_y == 10'(GRID_H - 1));
`endif
    pix_code = PIX_NONE;
    if (cell_x < 10'(GRID_W) && cell_y < 10'(GRID_H)) begin
      if (pix_wall) pix_code = PIX_WALL;
      for (int k = 1; k < MAX_LEN; k++) begin
        if (k < int'(len_q) && cell_x == 10'(seg_x[k]) && cell_y == 10'(seg_y[k])) begin
          pix_code = PIX_BODY;
        end
      end
      if (cell_x == 10'(seg_x[0]) && cell_y == 10'(seg_y[0])) pix_code = PIX_HEAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) snake <= PIX_NONE;
    else       snake <= pix_code;
  end

  assign head_x      = seg_x[0];
  assign head_y      = seg_y[0];
  assign len         = len_q;
  assign game_status = state_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine with a fast step divider and a short
// segment buffer; pixel queries are table-driven, game play is scripted.
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       left_press = 1'b0, right_press = 1'b0, up_press = 1'b0, down_press = 1'b0;
  logic       grow = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic [1:0] snake, game_status;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [2:0] len;
  logic       step, hit_wall, hit_body, die_flash;

  int total = 0;
  int bad   = 0;

`ifdef WRAP_WALLS_EN
  localparam logic [1:0] WALL_CODE = 2'b00;
`else
  localparam logic [1:0] WALL_CODE = 2'b11;
`endif

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic [1:0] exp_code;
  } pix_vec_t;

  pix_vec_t vecs[13];

  snake_engine #(
    .GRID_W(40), .GRID_H(30), .MAX_LEN(5), .INIT_LEN(3),
    .STEP_DIV(4), .CELL_SHIFT(4), .FLASH_STEPS(6)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .left_press(left_press), .right_press(right_press),
    .up_press(up_press), .down_press(down_press), .grow(grow),
    .pix_x(pix_x), .pix_y(pix_y), .snake(snake),
    .head_x(head_x), .head_y(head_y), .len(len), .game_status(game_status),
    .step(step), .hit_wall(hit_wall), .hit_body(hit_body), .die_flash(die_flash)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx);
    pix_x = vecs[idx].px;
    pix_y = vecs[idx].py;
    cyc();
    check_output($sformatf("pix_vec%0d", idx), 32'(snake), 32'(vecs[idx].exp_code));
  endtask

  // Waits for the next step/hit pulse; a missing pulse counts as a failure.
  task automatic wait_event(output int cycles);
    cycles = 0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      cycles = n + 1;
      if (step || hit_wall || hit_body) break;
    end
    if (!(step || hit_wall || hit_body)) begin
      total++;
      bad++;
      $display("[TB] FAIL tick_timeout: got no pulse expected pulse within 12 cycles");
    end
  endtask

  task automatic expect_move(input string name, input int ex, input int ey, input int elen);
    int c;
    wait_event(c);
    check_output({name, "_step"}, 32'(step), 1);
    check_output({name, "_x"}, 32'(head_x), 32'(ex));
    check_output({name, "_y"}, 32'(head_y), 32'(ey));
    check_output({name, "_len"}, 32'(len), 32'(elen));
  endtask

  task automatic pulse_dir(input logic u, input logic d, input logic l, input logic r);
    up_press = u; down_press = d; left_press = l; right_press = r;
    cyc();
    up_press = 0; down_press = 0; left_press = 0; right_press = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int c, toggles;
    logic prev;

    vecs[0]  = '{10'd320,  10'd240,  2'b01};
    vecs[1]  = '{10'd335,  10'd255,  2'b01};
    vecs[2]  = '{10'd304,  10'd240,  2'b10};
    vecs[3]  = '{10'd288,  10'd250,  2'b10};
    vecs[4]  = '{10'd272,  10'd240,  2'b00};
    vecs[5]  = '{10'd0,    10'd240,  WALL_CODE};
    vecs[6]  = '{10'd639,  10'd479,  WALL_CODE};
    vecs[7]  = '{10'd640,  10'd0,    2'b00};
    vecs[8]  = '{10'd100,  10'd480,  2'b00};
    vecs[9]  = '{10'd336,  10'd0,    WALL_CODE};
    vecs[10] = '{10'd336,  10'd256,  2'b00};
    vecs[11] = '{10'd1023, 10'd1023, 2'b00};
    vecs[12] = '{10'd16,   10'd16,   2'b00};

    cyc();
    cyc();
    check_output("rst_status", 32'(game_status), 0);
    check_output("rst_head_x", 32'(head_x), 20);
    check_output("rst_head_y", 32'(head_y), 15);
    check_output("rst_len", 32'(len), 3);
    check_output("rst_snake", 32'(snake), 0);
    check_output("rst_pulses", 32'({step, hit_wall, hit_body, die_flash}), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    check_output("idle_no_move", 32'(head_x), 20);

    for (int i = 0; i < 13; i++) apply_stimulus(i);

    $display("[TB] start and step timing");
    pulse_start();
    check_output("run_status", 32'(game_status), 1);
    wait_event(c);
    check_output("first_step_latency", 32'(c), 4);
    check_output("step1_x", 32'(head_x), 21);
    check_output("step1_y", 32'(head_y), 15);
    pix_x = 10'd336;
    pix_y = 10'd240;
    cyc();
    check_output("head_pixel", 32'(snake), 1);
    check_output("step_one_cycle", 32'(step), 0);

    $display("[TB] direction handling");
    pulse_dir(0, 0, 1, 0);
    expect_move("rev_ignored", 22, 15, 3);
    pulse_dir(1, 0, 0, 0);
    pulse_dir(0, 1, 0, 0);
    expect_move("last_wins", 22, 16, 3);
    pulse_dir(0, 0, 1, 1);
    expect_move("left_over_right", 21, 16, 3);

    $display("[TB] growth");
    grow = 1'b1;
    cyc(); cyc(); cyc();
    grow = 1'b0;
    expect_move("grow_once", 20, 16, 4);
    pulse_dir(1, 0, 0, 0);
    expect_move("loop_up", 20, 15, 4);
    pulse_dir(0, 0, 1, 0);
    expect_move("loop_left", 19, 15, 4);
    pulse_dir(0, 1, 0, 0);
    expect_move("loop_down", 19, 16, 4);
    pulse_dir(0, 0, 0, 1);
    expect_move("tail_legal", 20, 16, 4);
    check_output("tail_no_hit", 32'(hit_body), 0);
    grow = 1'b1; cyc(); grow = 1'b0;
    expect_move("grow_to_max", 21, 16, 5);
    grow = 1'b1; cyc(); grow = 1'b0;
    expect_move("grow_saturate", 22, 16, 5);

    $display("[TB] body collision and die sequence");
    pulse_dir(1, 0, 0, 0);
    expect_move("coil_up", 22, 15, 5);
    pulse_dir(0, 0, 1, 0);
    expect_move("coil_left", 21, 15, 5);
    pulse_dir(0, 1, 0, 0);
    wait_event(c);
    check_output("body_hit", 32'(hit_body), 1);
    check_output("body_no_step", 32'(step), 0);
    check_output("body_no_wall", 32'(hit_wall), 0);
    check_output("body_head_frozen", 32'({head_x, head_y}), 32'({6'd21, 5'd15}));
    check_output("die_status", 32'(game_status), 2);
    pulse_start();
    check_output("die_ignores_start", 32'(game_status), 2);
    check_output("hit_body_one_cycle", 32'(hit_body), 0);
    c = 1;
    toggles = 0;
    prev = die_flash;
    for (int n = 0; n < 40; n++) begin
      cyc();
      c++;
      if (die_flash !== prev) toggles++;
      prev = die_flash;
      if (game_status == 2'b11) break;
    end
    check_output("over_status", 32'(game_status), 3);
    check_output("over_latency", 32'(c), 24);
    check_output("flash_toggles", 32'(toggles), 6);
    check_output("over_flash_off", 32'(die_flash), 0);

    $display("[TB] restart and wall run");
    pulse_start();
    check_output("restart_status", 32'(game_status), 1);
    check_output("restart_head", 32'({head_x, head_y}), 32'({6'd20, 5'd15}));
    check_output("restart_len", 32'(len), 3);
    for (int i = 1; i <= 18; i++) begin
      expect_move($sformatf("run%0d", i), 20 + i, 15, 3);
      if (i == 5) pulse_start();
    end
`ifdef WRAP_WALLS_EN
    expect_move("wrap_edge", 39, 15, 3);
    expect_move("wrap_around", 0, 15, 3);
    check_output("wrap_no_wall", 32'(hit_wall), 0);
`else
    wait_event(c);
    check_output("wall_hit", 32'(hit_wall), 1);
    check_output("wall_no_step", 32'(step), 0);
    check_output("wall_head_frozen", 32'(head_x), 38);
    check_output("wall_die", 32'(game_status), 2);
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (game_status == 2'b11) break;
    end
    check_output("wall_over", 32'(game_status), 3);
    pulse_start();
    expect_move("replay_step", 21, 15, 3);
`endif

    $display("[TB] reset mid-game");
    reset = 1'b1;
    cyc();
    check_output("midrst_status", 32'(game_status), 0);
    check_output("midrst_head", 32'({head_x, head_y}), 32'({6'd20, 5'd15}));
    check_output("midrst_len", 32'(len), 3);
    reset = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
